// File: rtl/memctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
package memctrl_pkg;
  typedef enum logic [1:0] {IDLE, RD_LINE, RD_DATA, WR_DATA} state_e;

  localparam logic [2:0] LEN_1 = 3'd1;
  localparam logic [2:0] LEN_2 = 3'd2;
  localparam logic [2:0] LEN_4 = 3'd4;

  function automatic int blk_idx_w(input int blk_bytes);
    return $clog2(blk_bytes);
  endfunction

  // Anything other than 1 or 2 bytes is served as a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    return (len == LEN_1 || len == LEN_2) ? len : LEN_4;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant searched from ptr, ptr moves past winner on en.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr, gidx, idx;
  logic          found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     ptr <= '0;
    else if (en) ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
  end
endmodule

// File: rtl/memctrl_mc.sv
// Byte-serial controller: one line-fetch port plus NCH data ports onto a byte-wide RAM/IO bus.
module memctrl_mc
  import memctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BLK_BYTES = 64,
  parameter int NCH       = 2,
  parameter int IF_PRIO   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic [7:0]             mem_din,
  output logic [ADDR_W-1:0]      mem_a,
  output logic                   mem_wr,
  output logic [7:0]             mem_dout,
  input  logic                   io_buffer_full,
  input  logic                   if_req_valid,
  input  logic [ADDR_W-1:0]      if_req_addr,
  output logic                   if_resp_valid,
  output logic [BLK_BYTES*8-1:0] if_resp_data,
  input  logic [NCH-1:0]         d_req_valid,
  input  logic [NCH-1:0]         d_req_store,
  input  logic [NCH-1:0]         d_req_signed,
  input  logic [NCH*3-1:0]       d_req_len,
  input  logic [NCH*ADDR_W-1:0]  d_req_addr,
  input  logic [NCH*DATA_W-1:0]  d_req_wdata,
  output logic [NCH-1:0]         d_req_ack,
  output logic [NCH-1:0]         d_resp_valid,
  output logic [DATA_W-1:0]      d_resp_data
);
  localparam int CW    = blk_idx_w(BLK_BYTES);
  localparam int SLOTS = (IF_PRIO != 0) ? NCH : NCH + 1;

  typedef struct packed {
    logic              store;
    logic              sgn;
    logic [2:0]        len;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dreq_t;

  dreq_t [NCH-1:0]   req;
  dreq_t             sel;
  state_e            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        cur_len;
  logic              cur_sgn;
  logic [NCH-1:0]    cur_oh, ack_r, resp_r, d_grant;
  logic [DATA_W-1:0] wsh, acc, acc_nxt;
  logic              wr_en, if_resp_r, can_grant, if_win, arb_en, last;
  logic [SLOTS-1:0]  arb_req, arb_grant;

  for (genvar g = 0; g < NCH; g++) begin : g_req
    assign req[g] = '{store: d_req_store[g], sgn: d_req_signed[g],
                      len: norm_len(d_req_len[3*g +: 3]),
                      addr: d_req_addr[ADDR_W*g +: ADDR_W],
                      wdata: d_req_wdata[DATA_W*g +: DATA_W]};
  end

  // Idle one cycle after any response so the requester can drop its level.
  assign can_grant = (state == IDLE) && !rollback && !if_resp_r && (resp_r == '0);

  if (IF_PRIO != 0) begin : g_prio
    assign arb_req = d_req_valid;
    assign if_win  = if_req_valid;
    assign d_grant = if_req_valid ? '0 : arb_grant;
    assign arb_en  = rdy && can_grant && !if_req_valid && (d_req_valid != '0);
  end else begin : g_rr
    assign arb_req = {if_req_valid, d_req_valid};
    assign if_win  = arb_grant[NCH];
    assign d_grant = arb_grant[NCH-1:0];
    assign arb_en  = rdy && can_grant && (arb_req != '0);
  end

  rr_arbiter #(.N(SLOTS)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (arb_en),
    .req  (arb_req),
    .grant(arb_grant)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NCH; i++)
      if (d_grant[i]) sel = req[i];
  end

  always_comb begin
    acc_nxt = acc;
    acc_nxt[8*cnt[1:0] +: 8] = mem_din;
  end

  function automatic logic [DATA_W-1:0] ext(input logic [DATA_W-1:0] v, input logic [2:0] n,
                                            input logic s);
    case (n)
      LEN_1:   return {{24{s & v[7]}}, v[7:0]};
      LEN_2:   return {{16{s & v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  assign last = (state == RD_LINE) ? (cnt == CW'(BLK_BYTES - 1)) : (cnt == CW'(cur_len - 3'd1));

  assign mem_wr        = wr_en && rdy && !io_buffer_full;
  assign if_resp_valid = if_resp_r && rdy;
  assign d_req_ack     = ack_r & {NCH{rdy}};
  assign d_resp_valid  = resp_r & {NCH{rdy}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      cur_len      <= LEN_4;
      cur_sgn      <= 1'b0;
      cur_oh       <= '0;
      wsh          <= '0;
      acc          <= '0;
      wr_en        <= 1'b0;
      if_resp_r    <= 1'b0;
      ack_r        <= '0;
      resp_r       <= '0;
      mem_a        <= '0;
      mem_dout     <= '0;
      if_resp_data <= '0;
      d_resp_data  <= '0;
    end else if (rdy) begin
      if_resp_r <= 1'b0;
      ack_r     <= '0;
      resp_r    <= '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (can_grant && if_win) begin
            state <= RD_LINE;
            mem_a <= if_req_addr & ~ADDR_W'(BLK_BYTES - 1);
          end else if (can_grant && d_grant != '0) begin
            ack_r   <= d_grant;
            cur_oh  <= d_grant;
            cur_len <= sel.len;
            cur_sgn <= sel.sgn;
            mem_a   <= sel.addr;
            acc     <= '0;
            if (sel.store) begin
              state    <= WR_DATA;
              wr_en    <= 1'b1;
              mem_dout <= sel.wdata[7:0];
              wsh      <= sel.wdata >> 8;
            end else begin
              state <= RD_DATA;
            end
          end
        end
        RD_LINE, RD_DATA: begin
          if (rollback) begin
            state <= IDLE;
            mem_a <= '0;
          end else begin
            if (state == RD_LINE) if_resp_data[8*cnt +: 8] <= mem_din;
            else                  acc <= acc_nxt;
            if (last) begin
              state <= IDLE;
              mem_a <= '0;
              if (state == RD_LINE) begin
                if_resp_r <= 1'b1;
              end else begin
                resp_r      <= cur_oh;
                d_resp_data <= ext(acc_nxt, cur_len, cur_sgn);
              end
            end else begin
              cnt   <= cnt + 1'b1;
              mem_a <= mem_a + 1'b1;
            end
          end
        end
        WR_DATA: begin
          // A stalled byte stays on the bus until the IO sink has room.
          if (!io_buffer_full) begin
            if (last) begin
              state  <= IDLE;
              wr_en  <= 1'b0;
              resp_r <= cur_oh;
            end else begin
              cnt      <= cnt + 1'b1;
              mem_a    <= mem_a + 1'b1;
              mem_dout <= wsh[7:0];
              wsh      <= wsh >> 8;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
